// File: rtl/estagio_if_id.sv
// rtl/estagio_if_id.sv - IF/ID pipeline register with load-use stall, flush, freeze and stats
module estagio_if_id #(
    parameter int                 LARGURA   = 32,
    parameter logic [LARGURA-1:0] NOP       = 32'h0,
    parameter int                 LARG_CONT = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [LARGURA-1:0]   instrucao_in,
    input  logic [LARGURA-1:0]   pc_mais4_in,
    input  logic                 valido_in,
    input  logic                 desvio_tomado,
    input  logic                 congela,
    input  logic                 id_ex_mem_read,
    input  logic [4:0]           id_ex_rt,
    output logic [LARGURA-1:0]   instrucao_out,
    output logic [LARGURA-1:0]   pc_mais4_out,
    output logic                 valido_out,
    output logic                 pc_escreve,
    output logic                 bolha,
    output logic [LARG_CONT-1:0] cont_bolhas,
    output logic [LARG_CONT-1:0] cont_descartes
);

    typedef enum logic {EXEC, BOLHA} estado_t;

    localparam logic [LARG_CONT-1:0] UM = {{(LARG_CONT-1){1'b0}}, 1'b1};

    estado_t     estado;
    estado_t     prox_estado;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [5:0]  op;
    logic        usa_rt;
    logic        perigo;

    assign rs = instrucao_out[25:21];
    assign rt = instrucao_out[20:16];
    assign op = instrucao_out[31:26];

    // Only R-type, beq, bne and sw actually read rt as a source operand.
    assign usa_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);

    assign perigo = valido_out && id_ex_mem_read && (id_ex_rt != 5'd0) &&
                    ((id_ex_rt == rs) || (usa_rt && (id_ex_rt == rt)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= EXEC;
        end else begin
            estado <= prox_estado;
        end
    end

    always_comb begin
        prox_estado = estado;
        case (estado)
            EXEC:    if (perigo && !desvio_tomado) prox_estado = BOLHA;
            BOLHA:   prox_estado = EXEC;
            default: prox_estado = EXEC;
        endcase
    end

    always_comb begin
        bolha      = perigo && !desvio_tomado && (estado == EXEC);
        pc_escreve = !(bolha || (congela && !desvio_tomado));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instrucao_out  <= NOP;
            pc_mais4_out   <= '0;
            valido_out     <= 1'b0;
            cont_bolhas    <= '0;
            cont_descartes <= '0;
        end else if (desvio_tomado) begin
            instrucao_out <= NOP;
            pc_mais4_out  <= '0;
            valido_out    <= 1'b0;
            if (valido_out && (cont_descartes != '1)) begin
                cont_descartes <= cont_descartes + UM;
            end
        end else if (bolha) begin
            if (cont_bolhas != '1) begin
                cont_bolhas <= cont_bolhas + UM;
            end
        end else if (congela) begin
            instrucao_out <= instrucao_out;
        end else if (valido_in) begin
            instrucao_out <= instrucao_in;
            pc_mais4_out  <= pc_mais4_in;
            valido_out    <= 1'b1;
        end else begin
            // An empty fetch slot looks exactly like a flushed one downstream.
            instrucao_out <= NOP;
            pc_mais4_out  <= '0;
            valido_out    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_estagio_if_id.sv
// tb/tb_estagio_if_id.sv - scoreboard bench for estagio_if_id
module tb_estagio_if_id;

    logic        clock;
    logic        reset;
    logic [31:0] instrucao_in;
    logic [31:0] pc_mais4_in;
    logic        valido_in;
    logic        desvio_tomado;
    logic        congela;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_rt;
    logic [31:0] instrucao_out;
    logic [31:0] pc_mais4_out;
    logic        valido_out;
    logic        pc_escreve;
    logic        bolha;
    logic [15:0] cont_bolhas;
    logic [15:0] cont_descartes;

    logic        s_reset;
    logic [31:0] s_instrucao_out;
    logic [31:0] s_pc_mais4_out;
    logic        s_valido_out;
    logic        s_pc_escreve;
    logic        s_bolha;
    logic [2:0]  s_cont_bolhas;
    logic [2:0]  s_cont_descartes;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        v;
        logic        b;
        logic        pw;
        logic [15:0] cb;
        logic [15:0] cd;
    } exp_t;

    exp_t fila[$];

    estagio_if_id dut (
        .clock(clock), .reset(reset),
        .instrucao_in(instrucao_in), .pc_mais4_in(pc_mais4_in), .valido_in(valido_in),
        .desvio_tomado(desvio_tomado), .congela(congela),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
        .instrucao_out(instrucao_out), .pc_mais4_out(pc_mais4_out), .valido_out(valido_out),
        .pc_escreve(pc_escreve), .bolha(bolha),
        .cont_bolhas(cont_bolhas), .cont_descartes(cont_descartes)
    );

    estagio_if_id #(.LARG_CONT(3)) dut_sat (
        .clock(clock), .reset(s_reset),
        .instrucao_in(32'h012A4020), .pc_mais4_in(32'h4), .valido_in(1'b1),
        .desvio_tomado(1'b0), .congela(1'b0),
        .id_ex_mem_read(1'b1), .id_ex_rt(5'd9),
        .instrucao_out(s_instrucao_out), .pc_mais4_out(s_pc_mais4_out), .valido_out(s_valido_out),
        .pc_escreve(s_pc_escreve), .bolha(s_bolha),
        .cont_bolhas(s_cont_bolhas), .cont_descartes(s_cont_descartes)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checar(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
        n_checks++;
        if (atual === esperado) n_pass++;
        else $display("FAIL %s: got %h expected %h", nome, atual, esperado);
    endtask

    // Monitor: combinational outputs just before the edge, registered ones just after.
    always begin
        logic b_s, pw_s;
        exp_t e;
        @(negedge clock);
        #4;
        b_s  = bolha;
        pw_s = pc_escreve;
        @(posedge clock);
        #1;
        if (fila.size() > 0) begin
            e = fila.pop_front();
            n_checks++;
            if (instrucao_out === e.ins && pc_mais4_out === e.pc && valido_out === e.v &&
                b_s === e.b && pw_s === e.pw && cont_bolhas === e.cb && cont_descartes === e.cd) begin
                n_pass++;
            end else begin
                $display("FAIL passo: got ins=%h pc=%h v=%b b=%b pw=%b cb=%h cd=%h expected ins=%h pc=%h v=%b b=%b pw=%b cb=%h cd=%h",
                         instrucao_out, pc_mais4_out, valido_out, b_s, pw_s, cont_bolhas, cont_descartes,
                         e.ins, e.pc, e.v, e.b, e.pw, e.cb, e.cd);
            end
        end
    end

    task automatic passo(input logic [31:0] ins, input logic [31:0] pc, input logic vin,
                         input logic desv, input logic cong, input logic mr, input logic [4:0] rt,
                         input logic [31:0] e_ins, input logic [31:0] e_pc, input logic e_v,
                         input logic e_b, input logic e_pw, input logic [15:0] e_cb, input logic [15:0] e_cd);
        exp_t e;
        @(negedge clock);
        instrucao_in   = ins;
        pc_mais4_in    = pc;
        valido_in      = vin;
        desvio_tomado  = desv;
        congela        = cong;
        id_ex_mem_read = mr;
        id_ex_rt       = rt;
        e.ins = e_ins; e.pc = e_pc; e.v = e_v; e.b = e_b; e.pw = e_pw; e.cb = e_cb; e.cd = e_cd;
        fila.push_back(e);
    endtask

    initial begin
        reset = 1'b0; s_reset = 1'b1;
        instrucao_in = 32'h0; pc_mais4_in = 32'h0; valido_in = 1'b0;
        desvio_tomado = 1'b0; congela = 1'b0; id_ex_mem_read = 1'b0; id_ex_rt = 5'd0;
        #2 reset = 1'b1;
        #1;
        checar("reset_async", {instrucao_out, pc_mais4_out},  64'h0);
        checar("reset_flags", {valido_out, bolha, pc_escreve, cont_bolhas, cont_descartes},
               {1'b0, 1'b0, 1'b1, 16'h0, 16'h0});
        @(negedge clock);
        reset = 1'b0;

        //     ins           pc     vin dsv cng mr rt      e_ins         e_pc   v  b  pw  cb  cd
        passo(32'h012A4020, 32'h08, 1, 0, 0, 0, 5'd0,  32'h012A4020, 32'h08, 1, 0, 1, 16'd0, 16'd0);
        passo(32'h8C0B0004, 32'h0C, 1, 0, 0, 1, 5'd9,  32'h012A4020, 32'h08, 1, 1, 0, 16'd1, 16'd0);
        passo(32'h8C0B0004, 32'h0C, 1, 0, 0, 0, 5'd9,  32'h8C0B0004, 32'h0C, 1, 0, 1, 16'd1, 16'd0);
        passo(32'hAC0B0008, 32'h10, 1, 0, 0, 1, 5'd11, 32'hAC0B0008, 32'h10, 1, 0, 1, 16'd1, 16'd0);
        passo(32'h012A4020, 32'h14, 1, 0, 0, 1, 5'd0,  32'h012A4020, 32'h14, 1, 0, 1, 16'd1, 16'd0);
        passo(32'h11111111, 32'h18, 1, 1, 0, 1, 5'd10, 32'h0,        32'h0,  0, 0, 1, 16'd1, 16'd1);
        passo(32'hDEADBEEF, 32'h1C, 0, 0, 0, 0, 5'd0,  32'h0,        32'h0,  0, 0, 1, 16'd1, 16'd1);
        passo(32'h012A4020, 32'h20, 1, 1, 0, 0, 5'd0,  32'h0,        32'h0,  0, 0, 1, 16'd1, 16'd1);
        passo(32'h012A4020, 32'h24, 1, 0, 0, 0, 5'd0,  32'h012A4020, 32'h24, 1, 0, 1, 16'd1, 16'd1);
        passo(32'h8C0B0004, 32'h28, 1, 0, 1, 0, 5'd0,  32'h012A4020, 32'h24, 1, 0, 0, 16'd1, 16'd1);
        passo(32'h8C0B0004, 32'h28, 1, 0, 1, 0, 5'd0,  32'h012A4020, 32'h24, 1, 0, 0, 16'd1, 16'd1);
        passo(32'h8C0B0004, 32'h28, 1, 0, 1, 0, 5'd0,  32'h012A4020, 32'h24, 1, 0, 0, 16'd1, 16'd1);
        passo(32'h8C0B0004, 32'h28, 1, 0, 1, 1, 5'd9,  32'h012A4020, 32'h24, 1, 1, 0, 16'd2, 16'd1);
        passo(32'h8C0B0004, 32'h28, 1, 0, 1, 1, 5'd9,  32'h012A4020, 32'h24, 1, 0, 0, 16'd2, 16'd1);
        passo(32'h8C0B0004, 32'h28, 1, 0, 0, 0, 5'd0,  32'h8C0B0004, 32'h28, 1, 0, 1, 16'd2, 16'd1);
        passo(32'h012A4020, 32'h2C, 1, 1, 1, 0, 5'd0,  32'h0,        32'h0,  0, 0, 1, 16'd2, 16'd2);
        passo(32'h012A4020, 32'h2C, 1, 0, 0, 0, 5'd0,  32'h012A4020, 32'h2C, 1, 0, 1, 16'd2, 16'd2);

        for (int i = 0; i < 20 && fila.size() > 0; i++) @(posedge clock);
        #2;
        checar("fila_vazia", 64'(fila.size()), 64'd0);

        // Reset in the middle of a stall cycle drops the pending bubble.
        @(negedge clock);
        id_ex_mem_read = 1'b1;
        id_ex_rt       = 5'd9;
        #1 checar("perigo_pre_reset", {bolha, pc_escreve}, 2'b10);
        #1 reset = 1'b1;
        #1;
        checar("reset_meio", {instrucao_out, pc_mais4_out, valido_out, bolha, pc_escreve},
               {32'h0, 32'h0, 1'b0, 1'b0, 1'b1});
        checar("reset_meio_cont", {cont_bolhas, cont_descartes}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        id_ex_mem_read = 1'b0;
        valido_in = 1'b0;

        // Saturation on a 3-bit counter instance: one bubble every two edges.
        s_reset = 1'b0;
        repeat (6) @(posedge clock);
        #1 checar("sat_meio", 64'(s_cont_bolhas), 64'd3);
        repeat (30) @(posedge clock);
        #1 checar("sat_final", 64'(s_cont_bolhas), 64'd7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
